// File: rtl/serial_transmitter_if.sv
// Byte-level link between the transmit framer, the result shift register and the UART TX.
// The master side is the framer; the slave side is its environment.
interface serial_transmitter_if;
  logic [7:0] header_constant_i;
  logic       result_valid_i;
  logic [7:0] result_byte_i;
  logic       result_shift_out_o;
  logic [7:0] tx_byte_o;
  logic       new_tx_byte_o;
  logic       tx_busy_i;
  logic       busy_o;
  logic       done_o;
  logic       error_o;

  modport master (
    input  header_constant_i, result_valid_i, result_byte_i, tx_busy_i,
    output result_shift_out_o, tx_byte_o, new_tx_byte_o, busy_o, done_o, error_o
  );

  modport slave (
    output header_constant_i, result_valid_i, result_byte_i, tx_busy_i,
    input  result_shift_out_o, tx_byte_o, new_tx_byte_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/serial_transmitter.sv
// Transmit-side framer: sends a header byte followed by PAYLOAD_BYTES result bytes
// through the byte-wide UART TX, aborting the frame if the UART stalls too long.
module serial_transmitter #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  serial_transmitter_if.master link
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 2);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PAYLOAD_BYTES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [TMR_W-1:0] stall_r, stall_s;
  logic [7:0]       tx_byte_r, tx_byte_s;
  logic             strobe_r, strobe_s;
  logic             shift_r, shift_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             error_r, error_s;
  logic             stalled_s;
  logic             timeout_s;

  // The comparison uses >= so the abort still fires if the timer ever overshoots.
  assign stalled_s = ((state_r == ST_SEND) || (state_r == ST_WAIT)) && link.tx_busy_i;
  assign timeout_s = stalled_s && (stall_r >= TMR_LIMIT);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    stall_s   = stall_r;
    tx_byte_s = tx_byte_r;
    strobe_s  = 1'b0;
    shift_s   = 1'b0;
    done_s    = 1'b0;
    error_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s   = {CNT_W{1'b0}};
        stall_s = {TMR_W{1'b0}};
        if (link.result_valid_i) state_s = ST_SEND;
        else                     state_s = ST_IDLE;
      end
      ST_SEND: begin
        if (timeout_s) begin
          error_s = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          stall_s = {TMR_W{1'b0}};
          state_s = ST_IDLE;
        end else if (!link.tx_busy_i) begin
          strobe_s  = 1'b1;
          tx_byte_s = (cnt_r == {CNT_W{1'b0}}) ? link.header_constant_i : link.result_byte_i;
          shift_s   = (cnt_r != {CNT_W{1'b0}});
          cnt_s     = cnt_r + CNT_W'(1);
          stall_s   = {TMR_W{1'b0}};
          state_s   = ST_GAP;
        end else begin
          stall_s = stall_r + TMR_W'(1);
          state_s = ST_SEND;
        end
      end
      // UART raises busy one cycle after the strobe, so busy is not trusted here.
      ST_GAP: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (timeout_s) begin
          error_s = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          stall_s = {TMR_W{1'b0}};
          state_s = ST_IDLE;
        end else if (!link.tx_busy_i) begin
          if (cnt_r == CNT_LAST) begin
            done_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          stall_s = stall_r + TMR_W'(1);
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        cnt_s   = {CNT_W{1'b0}};
        stall_s = {TMR_W{1'b0}};
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        stall_s = {TMR_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      stall_r   <= {TMR_W{1'b0}};
      tx_byte_r <= 8'h00;
      strobe_r  <= 1'b0;
      shift_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      stall_r   <= stall_s;
      tx_byte_r <= tx_byte_s;
      strobe_r  <= strobe_s;
      shift_r   <= shift_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      error_r   <= error_s;
    end
  end

  assign link.tx_byte_o          = tx_byte_r;
  assign link.new_tx_byte_o      = strobe_r;
  assign link.result_shift_out_o = shift_r;
  assign link.busy_o             = busy_r;
  assign link.done_o             = done_r;
  assign link.error_o            = error_r;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: one instance with a UART/shift-register model,
// and a second instance with a short timeout driven by hand.
module tb_serial_transmitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_transmitter_if m ();
  serial_transmitter_if t ();

  serial_transmitter #(.PAYLOAD_BYTES(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .link(m)
  );

  serial_transmitter #(.PAYLOAD_BYTES(4), .TIMEOUT_CYCLES(8)) u_dut_to (
    .clk_i(clk), .rst_n_i(rst_n), .link(t)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Environment of the main instance: result shift register and UART busy model.
  logic [7:0] mem [0:15];
  int         n_shift_total = 0;
  int         sr_base = 0;
  int         busy_len = 0;
  int         ub_cnt = 0;
  assign m.result_byte_i = mem[4'(n_shift_total - sr_base)];
  assign m.tx_busy_i     = (ub_cnt != 0);

  int t_nshift = 0;
  assign t.result_byte_i = 8'h40 + 8'(t_nshift);

  int       strobe_cyc [$];
  logic [7:0] tx_cap   [$];
  int       done_cyc   [$];
  int       n_err_pulse = 0;
  int       n_busy_hi = 0;
  int       t_strobe_cyc [$];
  logic [7:0] t_cap    [$];
  int       t_done_n = 0;
  int       t_err_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m.result_shift_out_o) n_shift_total <= n_shift_total + 1;
    if (m.new_tx_byte_o)      ub_cnt <= busy_len;
    else if (ub_cnt > 0)      ub_cnt <= ub_cnt - 1;
    if (t.result_shift_out_o) t_nshift <= t_nshift + 1;
  end

  always @(negedge clk) begin
    if (m.new_tx_byte_o) begin
      strobe_cyc.push_back(cyc);
      tx_cap.push_back(m.tx_byte_o);
    end
    if (m.done_o)  done_cyc.push_back(cyc);
    if (m.error_o) n_err_pulse <= n_err_pulse + 1;
    if (m.busy_o)  n_busy_hi <= n_busy_hi + 1;
    if (t.new_tx_byte_o) begin
      t_strobe_cyc.push_back(cyc);
      t_cap.push_back(t.tx_byte_o);
    end
    if (t.done_o)  t_done_n <= t_done_n + 1;
    if (t.error_o) t_err_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cyc.size() < target && k < budget) begin
      step();
      k++;
    end
    chk("wait_done_bound", 32'(done_cyc.size() >= target), 32'd1);
  endtask

  task automatic pulse_valid();
    m.result_valid_i = 1'b1;
    step();
    m.result_valid_i = 1'b0;
  endtask

  initial begin
    int c0, s0, nd0, ne0, ts0, te0, td0, g, k;
    logic [7:0] hdr;

    // Reset held with random inputs: every output stays zero.
    for (int i = 0; i < 6; i++) begin
      m.header_constant_i = 8'($urandom);
      m.result_valid_i    = 1'($urandom);
      t.header_constant_i = 8'($urandom);
      t.result_valid_i    = 1'($urandom);
      t.tx_busy_i         = 1'($urandom);
      step();
      chk("reset_outputs_main", 32'({m.tx_byte_o, m.new_tx_byte_o, m.result_shift_out_o,
                                     m.busy_o, m.done_o, m.error_o}), 32'd0);
      chk("reset_outputs_to", 32'({t.tx_byte_o, t.new_tx_byte_o, t.result_shift_out_o,
                                   t.busy_o, t.done_o, t.error_o}), 32'd0);
    end
    m.result_valid_i = 1'b0;
    t.result_valid_i = 1'b0;
    t.tx_busy_i      = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step();
    chk("idle_strobes", 32'(strobe_cyc.size() + t_strobe_cyc.size()), 32'd0);
    chk("idle_shifts", 32'(n_shift_total + t_nshift), 32'd0);
    chk("idle_busy", 32'(n_busy_hi), 32'd0);
    chk("idle_done_err", 32'(done_cyc.size() + n_err_pulse + t_done_n + t_err_cyc.size()), 32'd0);

    // Normal frame, UART busy 10 cycles per byte.
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    sr_base = n_shift_total;
    busy_len = 10;
    m.header_constant_i = 8'hA5;
    s0 = strobe_cyc.size(); nd0 = done_cyc.size();
    pulse_valid();
    wait_done(nd0 + 1, 300);
    chk("normal_busy_at_done", 32'(m.busy_o), 32'd1);
    step();
    chk("normal_busy_after_done", 32'(m.busy_o), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("normal_nbytes", 32'(strobe_cyc.size() - s0), 32'd5);
    chk("normal_byte0", 32'(tx_cap[s0]), 32'hA5);
    for (int i = 1; i < 5; i++) chk("normal_payload", 32'(tx_cap[s0 + i]), 32'(i));
    chk("normal_shifts", 32'(n_shift_total - sr_base), 32'd4);
    chk("normal_done_count", 32'(done_cyc.size() - nd0), 32'd1);

    // Never-busy UART: exact cycle positions relative to the request cycle.
    busy_len = 0;
    sr_base = n_shift_total;
    s0 = strobe_cyc.size(); nd0 = done_cyc.size();
    c0 = cyc;
    pulse_valid();
    chk("nb_busy_rise", 32'(m.busy_o), 32'd1);
    wait_done(nd0 + 1, 100);
    for (int i = 0; i < 5; i++)
      chk("nb_strobe_cycle", 32'(strobe_cyc[s0 + i] - c0), 32'(2 + 3 * i));
    chk("nb_done_cycle", 32'(done_cyc[nd0] - c0), 32'd16);
    step();
    chk("nb_busy_low", 32'(m.busy_o), 32'd0);

    // Request held high: three back-to-back frames.
    busy_len = 2;
    for (int i = 0; i < 12; i++) mem[i] = 8'(8'h10 + i);
    sr_base = n_shift_total;
    m.header_constant_i = 8'hC3;
    s0 = strobe_cyc.size(); nd0 = done_cyc.size();
    m.result_valid_i = 1'b1;
    wait_done(nd0 + 3, 600);
    m.result_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("cont_nbytes", 32'(strobe_cyc.size() - s0), 32'd15);
    chk("cont_shifts", 32'(n_shift_total - sr_base), 32'd12);
    for (int f = 0; f < 3; f++) begin
      chk("cont_header", 32'(tx_cap[s0 + 5 * f]), 32'hC3);
      for (int b = 1; b < 5; b++)
        chk("cont_payload", 32'(tx_cap[s0 + 5 * f + b]), 32'(8'h10 + 4 * f + b - 1));
    end
    for (int f = 0; f < 2; f++)
      chk("cont_done_to_strobe", 32'(strobe_cyc[s0 + 5 * (f + 1)] - done_cyc[nd0 + f]), 32'd3);

    // Reset asserted right after the third strobe.
    busy_len = 3;
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h21 + i);
    sr_base = n_shift_total;
    hdr = 8'h96;
    m.header_constant_i = hdr;
    s0 = strobe_cyc.size(); nd0 = done_cyc.size(); ne0 = n_err_pulse;
    pulse_valid();
    k = 0;
    while (strobe_cyc.size() < s0 + 3 && k < 100) begin
      step();
      k++;
    end
    chk("rst_mid_third_strobe", 32'(strobe_cyc.size() - s0), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_clear", 32'({m.tx_byte_o, m.new_tx_byte_o, m.result_shift_out_o,
                                    m.busy_o, m.done_o, m.error_o}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("rst_mid_no_done_err", 32'(done_cyc.size() - nd0 + n_err_pulse - ne0), 32'd0);
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h31 + i);
    sr_base = n_shift_total;
    s0 = strobe_cyc.size();
    pulse_valid();
    wait_done(nd0 + 1, 200);
    chk("rst_mid_next_header", 32'(tx_cap[s0]), 32'(hdr));
    for (int i = 1; i < 5; i++) chk("rst_mid_next_payload", 32'(tx_cap[s0 + i]), 32'(8'h30 + i));

    // Timeout instance: UART stuck busy after the second strobe.
    t.header_constant_i = 8'h5A;
    t.tx_busy_i = 1'b0;
    ts0 = t_strobe_cyc.size(); te0 = t_err_cyc.size(); td0 = t_done_n;
    t.result_valid_i = 1'b1;
    step();
    t.result_valid_i = 1'b0;
    k = 0;
    while (t_strobe_cyc.size() < ts0 + 2 && k < 50) begin
      step();
      k++;
    end
    chk("to_second_strobe", 32'(t_strobe_cyc.size() - ts0), 32'd2);
    g = t_strobe_cyc[ts0 + 1];
    t.tx_busy_i = 1'b1;
    k = 0;
    while (t_err_cyc.size() <= te0 && k < 40) begin
      step();
      k++;
    end
    chk("to_error_seen", 32'(t_err_cyc.size() - te0), 32'd1);
    if (t_err_cyc.size() > te0) begin
      chk("to_error_cycle", 32'(t_err_cyc[te0] - g), 32'd9);
      chk("to_busy_dropped", 32'(t.busy_o), 32'd0);
    end else begin
      chk("to_error_cycle", 32'd0, 32'd9);
    end
    for (int i = 0; i < 20; i++) step();
    chk("to_single_error", 32'(t_err_cyc.size() - te0), 32'd1);
    chk("to_no_third_strobe", 32'(t_strobe_cyc.size() - ts0), 32'd2);
    chk("to_no_done", 32'(t_done_n - td0), 32'd0);
    t.tx_busy_i = 1'b0;
    t.result_valid_i = 1'b1;
    step();
    t.result_valid_i = 1'b0;
    k = 0;
    while (t_done_n == td0 && k < 100) begin
      step();
      k++;
    end
    chk("to_recover_done", 32'(t_done_n - td0), 32'd1);
    chk("to_recover_nbytes", 32'(t_strobe_cyc.size() - ts0), 32'd7);
    chk("to_recover_header", 32'(t_cap[ts0 + 2]), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
